banked_pregfile: RTL and testbench

//  Physical integer register file, successor of the flat regfile: banked storage, arbitrated read ports and a ready

---
 rtl/banked_pregfile_pkg.sv | 41 ++++
 rtl/banked_pregfile_bank_arbiter.sv | 22 ++
 rtl/banked_pregfile.sv | 181 ++++++++++++++++++
 tb/tb_banked_pregfile.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banked_pregfile_pkg.sv
// Shared backend definitions for the banked physical register file: sizing, index types and bank helpers.
package banked_pregfile_pkg;

  localparam int SIZE          = 128;
  localparam int BANKS         = 2;
  localparam int BANK_RD_PORTS = 3;
  localparam int READPORT_NUM  = 8;
  localparam int WBPORT_NUM    = 4;
  localparam int RENAME_NUM    = 4;
  localparam int CHECK_NUM     = 8;
  localparam int CANCEL_NUM    = 2;
  localparam int INIT_READY    = 32;
  localparam int DATA_W        = 64;
  localparam int HAS_ZERO      = 1;

  localparam int IDX_W  = $clog2(SIZE);
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int ROWS   = SIZE / BANKS;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef logic [IDX_W-1:0] pregIdx_t;

  typedef struct packed {
    logic     vld;
    pregIdx_t idx;
  } rf_rd_req_t;

  // Low index bits select the bank, the remaining bits select the row inside it.
  function automatic logic [BANK_W-1:0] bank_of(input pregIdx_t idx);
    return BANK_W'(idx & pregIdx_t'(BANKS - 1));
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input pregIdx_t idx);
    return ROW_W'(idx >> $clog2(BANKS));
  endfunction

  function automatic logic is_zero_reg(input pregIdx_t idx);
    return (HAS_ZERO != 0) && (idx == '0);
  endfunction

endpackage

// File: rtl/banked_pregfile_bank_arbiter.sv
// rf_bank_arbiter: grants the lowest-numbered requests of one bank, up to K of them per cycle.
module rf_bank_arbiter #(
  parameter int N = 8,
  parameter int K = 3
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o
);

  always_comb begin : arb
    int cnt;
    cnt     = 0;
    grant_o = '0;
    for (int p = 0; p < N; p++) begin
      if (req_i[p] && (cnt < K)) begin
        grant_o[p] = 1'b1;
        cnt        = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/banked_pregfile.sv
// banked_pregfile: banked physical register file with per-bank read arbitration and a ready scoreboard.
// Define PREGFILE_WB_BYPASS_EN to forward same-cycle write data (and ready=1) to granted reads.
module banked_pregfile
  import banked_pregfile_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RENAME_NUM-1:0]          i_notready_mark,
  input  logic [RENAME_NUM*IDX_W-1:0]    i_notready_idx,
  input  logic [CANCEL_NUM-1:0]          i_cancel_en,
  input  logic [CANCEL_NUM*IDX_W-1:0]    i_cancel_idx,
  input  logic [CHECK_NUM*IDX_W-1:0]     i_check_idx,
  output logic [CHECK_NUM-1:0]           o_check_rdy,
  input  logic [READPORT_NUM-1:0]        i_rd_req,
  input  logic [READPORT_NUM*IDX_W-1:0]  i_rd_idx,
  output logic [READPORT_NUM-1:0]        o_rd_grant,
  output logic [READPORT_NUM-1:0]        o_rd_vld,
  output logic [READPORT_NUM*DATA_W-1:0] o_rd_data,
  output logic [READPORT_NUM-1:0]        o_rd_rdy,
  input  logic [WBPORT_NUM-1:0]          i_wr_en,
  input  logic [WBPORT_NUM*IDX_W-1:0]    i_wr_idx,
  input  logic [WBPORT_NUM*DATA_W-1:0]   i_wr_data,
  output logic                           o_dbl_wr_err
);

  rf_rd_req_t        rdReq     [READPORT_NUM];
  pregIdx_t          wrIdx     [WBPORT_NUM];
  logic [DATA_W-1:0] wrData    [WBPORT_NUM];
  pregIdx_t          markIdx   [RENAME_NUM];
  pregIdx_t          cancelIdx [CANCEL_NUM];
  pregIdx_t          checkIdx  [CHECK_NUM];

  logic [SIZE-1:0]         rdy_q, rdy_d;
  logic [DATA_W-1:0]       mem_q [BANKS][ROWS];
  logic [READPORT_NUM-1:0] rdVld_q;
  logic [READPORT_NUM-1:0] rdRdy_q, rdRdy_d;
  logic [DATA_W-1:0]       rdData_q [READPORT_NUM];
  logic [DATA_W-1:0]       rdData_d [READPORT_NUM];
  logic                    err_q, err_d;

  logic [READPORT_NUM-1:0] bankReq   [BANKS];
  logic [READPORT_NUM-1:0] bankGrant [BANKS];
  logic [READPORT_NUM-1:0] grant;

  for (genvar k = 0; k < READPORT_NUM; k++) begin : g_rd_port
    assign rdReq[k] = '{vld: i_rd_req[k], idx: i_rd_idx[k*IDX_W +: IDX_W]};
    assign o_rd_data[k*DATA_W +: DATA_W] = rdData_q[k];
  end

  for (genvar k = 0; k < WBPORT_NUM; k++) begin : g_wr_port
    assign wrIdx[k]  = i_wr_idx[k*IDX_W +: IDX_W];
    assign wrData[k] = i_wr_data[k*DATA_W +: DATA_W];
  end

  for (genvar k = 0; k < RENAME_NUM; k++) begin : g_mark_port
    assign markIdx[k] = i_notready_idx[k*IDX_W +: IDX_W];
  end

  for (genvar k = 0; k < CANCEL_NUM; k++) begin : g_cancel_port
    assign cancelIdx[k] = i_cancel_idx[k*IDX_W +: IDX_W];
  end

  for (genvar k = 0; k < CHECK_NUM; k++) begin : g_check_port
    assign checkIdx[k]    = i_check_idx[k*IDX_W +: IDX_W];
    assign o_check_rdy[k] = rdy_d[checkIdx[k]];
  end

  // The zero register never competes for a bank port, so it is kept out of the arbiters.
  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      bankReq[b] = '0;
      for (int p = 0; p < READPORT_NUM; p++) begin
        bankReq[b][p] = rdReq[p].vld && !is_zero_reg(rdReq[p].idx) &&
                        (bank_of(rdReq[p].idx) == BANK_W'(b));
      end
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    rf_bank_arbiter #(
      .N(READPORT_NUM),
      .K(BANK_RD_PORTS)
    ) u_arb (
      .req_i  (bankReq[b]),
      .grant_o(bankGrant[b])
    );
  end

  always_comb begin
    grant = '0;
    for (int p = 0; p < READPORT_NUM; p++) begin
      grant[p] = rdReq[p].vld && is_zero_reg(rdReq[p].idx);
    end
    for (int b = 0; b < BANKS; b++) begin
      grant = grant | bankGrant[b];
    end
  end

  // Later clears/sets overwrite earlier ones, so a write beats a cancel to the same register.
  always_comb begin
    rdy_d = rdy_q;
    for (int k = 0; k < RENAME_NUM; k++) begin
      if (i_notready_mark[k]) rdy_d[markIdx[k]] = 1'b0;
    end
    for (int k = 0; k < CANCEL_NUM; k++) begin
      if (i_cancel_en[k]) rdy_d[cancelIdx[k]] = 1'b0;
    end
    for (int k = 0; k < WBPORT_NUM; k++) begin
      if (i_wr_en[k] && !is_zero_reg(wrIdx[k])) rdy_d[wrIdx[k]] = 1'b1;
    end
    if (HAS_ZERO != 0) rdy_d[0] = 1'b1;
  end

  always_comb begin
    err_d = err_q;
    for (int w = 0; w < WBPORT_NUM; w++) begin
      if (i_wr_en[w] && !is_zero_reg(wrIdx[w])) begin
        if (rdy_q[wrIdx[w]]) err_d = 1'b1;
        for (int v = w + 1; v < WBPORT_NUM; v++) begin
          if (i_wr_en[v] && (wrIdx[v] == wrIdx[w])) err_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < READPORT_NUM; p++) begin
      rdData_d[p] = '0;
      rdRdy_d[p]  = 1'b0;
      if (grant[p]) begin
        if (is_zero_reg(rdReq[p].idx)) begin
          rdRdy_d[p] = 1'b1;
        end else begin
          rdData_d[p] = mem_q[bank_of(rdReq[p].idx)][row_of(rdReq[p].idx)];
          rdRdy_d[p]  = rdy_q[rdReq[p].idx];
`ifdef PREGFILE_WB_BYPASS_EN
          for (int w = 0; w < WBPORT_NUM; w++) begin
            if (i_wr_en[w] && (wrIdx[w] == rdReq[p].idx)) begin
              rdData_d[p] = wrData[w];
              rdRdy_d[p]  = 1'b1;
            end
          end
`endif
        end
      end
    end
  end

  // Storage carries no reset; ascending port order lets the highest write port win.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WBPORT_NUM; w++) begin
      if (i_wr_en[w] && !is_zero_reg(wrIdx[w])) begin
        mem_q[bank_of(wrIdx[w])][row_of(wrIdx[w])] <= wrData[w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        rdy_q[i] <= (i < INIT_READY) || ((i == 0) && (HAS_ZERO != 0));
      end
      rdVld_q <= '0;
      rdRdy_q <= '0;
      err_q   <= 1'b0;
      for (int p = 0; p < READPORT_NUM; p++) rdData_q[p] <= '0;
    end else begin
      rdy_q   <= rdy_d;
      rdVld_q <= grant;
      rdRdy_q <= rdRdy_d;
      err_q   <= err_d;
      for (int p = 0; p < READPORT_NUM; p++) rdData_q[p] <= rdData_d[p];
    end
  end

  assign o_rd_grant   = grant;
  assign o_rd_vld     = rdVld_q;
  assign o_rd_rdy     = rdRdy_q;
  assign o_dbl_wr_err = err_q;

endmodule

// File: tb/tb_banked_pregfile.sv
// Directed bench for banked_pregfile: table-driven ready/read vectors plus hand sequences for multi-cycle cases.
module tb_banked_pregfile;
  import banked_pregfile_pkg::*;

  logic                           clk;
  logic                           rst;
  logic [RENAME_NUM-1:0]          markEn;
  logic [RENAME_NUM*IDX_W-1:0]    markIdx;
  logic [CANCEL_NUM-1:0]          cancelEn;
  logic [CANCEL_NUM*IDX_W-1:0]    cancelIdx;
  logic [CHECK_NUM*IDX_W-1:0]     checkIdx;
  logic [CHECK_NUM-1:0]           checkRdy;
  logic [READPORT_NUM-1:0]        rdReq;
  logic [READPORT_NUM*IDX_W-1:0]  rdIdx;
  logic [READPORT_NUM-1:0]        rdGrant;
  logic [READPORT_NUM-1:0]        rdVld;
  logic [READPORT_NUM*DATA_W-1:0] rdData;
  logic [READPORT_NUM-1:0]        rdRdy;
  logic [WBPORT_NUM-1:0]          wrEn;
  logic [WBPORT_NUM*IDX_W-1:0]    wrIdx;
  logic [WBPORT_NUM*DATA_W-1:0]   wrData;
  logic                           dblWrErr;

  int nVec  = 0;
  int nMiss = 0;

  typedef struct {
    int   idx;
    logic expRdy;
  } chkVec_t;

  typedef struct {
    int          idx;
    logic [63:0] expData;
  } rdVec_t;

  chkVec_t chkTab [CHECK_NUM];
  rdVec_t  rdTab  [READPORT_NUM];

  banked_pregfile dut (
    .clk            (clk),
    .rst            (rst),
    .i_notready_mark(markEn),
    .i_notready_idx (markIdx),
    .i_cancel_en    (cancelEn),
    .i_cancel_idx   (cancelIdx),
    .i_check_idx    (checkIdx),
    .o_check_rdy    (checkRdy),
    .i_rd_req       (rdReq),
    .i_rd_idx       (rdIdx),
    .o_rd_grant     (rdGrant),
    .o_rd_vld       (rdVld),
    .o_rd_data      (rdData),
    .o_rd_rdy       (rdRdy),
    .i_wr_en        (wrEn),
    .i_wr_idx       (wrIdx),
    .i_wr_data      (wrData),
    .o_dbl_wr_err   (dblWrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] dataOf(input int idx);
    return 64'hA5A5_0000_0000_0000 | 64'(idx);
  endfunction

  function automatic logic [63:0] portData(input int p);
    return rdData[p*DATA_W +: DATA_W];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clearInputs();
    markEn = '0;  markIdx = '0;
    cancelEn = '0; cancelIdx = '0;
    checkIdx = '0;
    rdReq = '0;   rdIdx = '0;
    wrEn = '0;    wrIdx = '0;  wrData = '0;
  endtask

  task automatic setRd(input int p, input int idx);
    rdReq[p] = 1'b1;
    rdIdx[p*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  task automatic setWr(input int p, input int idx, input logic [63:0] d);
    wrEn[p] = 1'b1;
    wrIdx[p*IDX_W +: IDX_W] = IDX_W'(idx);
    wrData[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic setMark(input int p, input int idx);
    markEn[p] = 1'b1;
    markIdx[p*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  task automatic setCancel(input int p, input int idx);
    cancelEn[p] = 1'b1;
    cancelIdx[p*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  task automatic setCheck(input int p, input int idx);
    checkIdx[p*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  task automatic applyStimulus();
    clearInputs();
    for (int k = 0; k < CHECK_NUM; k++) setCheck(k, chkTab[k].idx);
    settle();
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    chkTab[0] = '{5, 1'b1};   chkTab[1] = '{40, 1'b0};
    chkTab[2] = '{0, 1'b1};   chkTab[3] = '{31, 1'b1};
    chkTab[4] = '{32, 1'b0};  chkTab[5] = '{127, 1'b0};
    chkTab[6] = '{1, 1'b1};   chkTab[7] = '{96, 1'b0};

    rdTab[0] = '{0, 64'h0};  rdTab[1] = '{0, 64'h0};
    rdTab[2] = '{0, 64'h0};  rdTab[3] = '{0, 64'h0};
    rdTab[4] = '{0, 64'h0};  rdTab[5] = '{2, dataOf(2)};
    rdTab[6] = '{4, dataOf(4)}; rdTab[7] = '{6, dataOf(6)};

    // Reset state and initial ready vector
    doReset();
    checkOutput("rst_vld", 64'(rdVld), 64'h0);
    checkOutput("rst_rdy", 64'(rdRdy), 64'h0);
    checkOutput("rst_data0", portData(0), 64'h0);
    checkOutput("rst_err", 64'(dblWrErr), 64'h0);
    applyStimulus();
    for (int k = 0; k < CHECK_NUM; k++) begin
      checkOutput($sformatf("init_rdy_p%0d", chkTab[k].idx), 64'(checkRdy[k]), 64'(chkTab[k].expRdy));
    end

    // Four bank-0 reads: only three bank ports, port 3 retries
    clearInputs();
    for (int k = 0; k < 4; k++) setMark(k, 2 * (k + 1));
    tick();
    clearInputs();
    for (int k = 0; k < 4; k++) setWr(k, 2 * (k + 1), dataOf(2 * (k + 1)));
    tick();
    clearInputs();
    for (int k = 0; k < 4; k++) setRd(k, 2 * (k + 1));
    settle();
    checkOutput("arb_grant_first", 64'(rdGrant), 64'h07);
    tick();
    checkOutput("arb_vld_first", 64'(rdVld), 64'h07);
    checkOutput("arb_rdy_first", 64'(rdRdy), 64'h07);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("arb_data_port%0d", k), portData(k), dataOf(2 * (k + 1)));
    end
    checkOutput("arb_data_port3_denied", portData(3), 64'h0);
    clearInputs();
    setRd(3, 8);
    settle();
    checkOutput("arb_grant_retry", 64'(rdGrant), 64'h08);
    tick();
    checkOutput("arb_vld_retry", 64'(rdVld), 64'h08);
    checkOutput("arb_data_retry", portData(3), dataOf(8));
    checkOutput("arb_err_clean", 64'(dblWrErr), 64'h0);

    // Same-cycle write/read of p40
    clearInputs();
    setWr(1, 40, 64'h1111);
    tick();
    clearInputs();
    setMark(0, 40);
    tick();
    clearInputs();
    setWr(0, 40, 64'hDEAD);
    setRd(0, 40);
    setCheck(0, 40);
    settle();
    checkOutput("wr40_check_rdy", 64'(checkRdy[0]), 64'h1);
    checkOutput("wr40_grant", 64'(rdGrant[0]), 64'h1);
    tick();
    checkOutput("wr40_vld_same", 64'(rdVld[0]), 64'h1);
`ifdef PREGFILE_WB_BYPASS_EN
    checkOutput("wr40_data_same", portData(0), 64'hDEAD);
    checkOutput("wr40_rdy_same", 64'(rdRdy[0]), 64'h1);
`else
    checkOutput("wr40_data_same", portData(0), 64'h1111);
    checkOutput("wr40_rdy_same", 64'(rdRdy[0]), 64'h0);
`endif
    clearInputs();
    setRd(0, 40);
    tick();
    checkOutput("wr40_data_next", portData(0), 64'hDEAD);
    checkOutput("wr40_rdy_next", 64'(rdRdy[0]), 64'h1);

    // Write beats cancel; cancel alone clears
    clearInputs();
    setMark(2, 50);
    setCheck(0, 50);
    settle();
    checkOutput("p50_mark_rdy", 64'(checkRdy[0]), 64'h0);
    tick();
    clearInputs();
    setWr(2, 50, 64'h5050);
    setCancel(1, 50);
    setCheck(0, 50);
    settle();
    checkOutput("p50_wr_cancel_comb", 64'(checkRdy[0]), 64'h1);
    tick();
    clearInputs();
    setCheck(3, 50);
    settle();
    checkOutput("p50_wr_cancel_reg", 64'(checkRdy[3]), 64'h1);
    setCancel(0, 50);
    settle();
    checkOutput("p50_cancel_comb", 64'(checkRdy[3]), 64'h0);
    tick();
    clearInputs();
    setCheck(3, 50);
    settle();
    checkOutput("p50_cancel_reg", 64'(checkRdy[3]), 64'h0);
    checkOutput("p50_err_clean", 64'(dblWrErr), 64'h0);

    // Double write: highest port wins and the flag sets
    clearInputs();
    setWr(0, 60, 64'hAAAA);
    setWr(2, 60, 64'hBBBB);
    tick();
    checkOutput("p60_dbl_err", 64'(dblWrErr), 64'h1);
    clearInputs();
    setRd(5, 60);
    tick();
    checkOutput("p60_data", portData(5), 64'hBBBB);

    // Reset during an in-flight read drops the result
    clearInputs();
    setRd(1, 60);
    rst = 1'b1;
    tick();
    checkOutput("midrst_vld", 64'(rdVld), 64'h0);
    checkOutput("midrst_err", 64'(dblWrErr), 64'h0);
    rst = 1'b0;
    clearInputs();
    setWr(3, 10, 64'h1010);
    tick();
    checkOutput("p10_err_set", 64'(dblWrErr), 64'h1);
    clearInputs();
    tick();
    tick();
    tick();
    checkOutput("p10_err_sticky", 64'(dblWrErr), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("p10_err_cleared", 64'(dblWrErr), 64'h0);

    // Zero register: writes ignored, reads never consume bank ports
    clearInputs();
    setWr(0, 0, 64'h7);
    setCheck(0, 0);
    settle();
    checkOutput("p0_check_rdy", 64'(checkRdy[0]), 64'h1);
    tick();
    clearInputs();
    for (int k = 0; k < READPORT_NUM; k++) setRd(k, 0);
    settle();
    checkOutput("p0_grant_all", 64'(rdGrant), 64'hFF);
    tick();
    checkOutput("p0_vld_all", 64'(rdVld), 64'hFF);
    checkOutput("p0_rdy_all", 64'(rdRdy), 64'hFF);
    for (int k = 0; k < READPORT_NUM; k++) begin
      checkOutput($sformatf("p0_data_port%0d", k), portData(k), 64'h0);
    end
    clearInputs();
    for (int k = 0; k < READPORT_NUM; k++) setRd(k, rdTab[k].idx);
    settle();
    checkOutput("mix_grant", 64'(rdGrant), 64'hFF);
    tick();
    checkOutput("mix_vld", 64'(rdVld), 64'hFF);
    for (int k = 0; k < READPORT_NUM; k++) begin
      checkOutput($sformatf("mix_data_port%0d", k), portData(k), rdTab[k].expData);
    end

    clearInputs();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
